drw_vramwr_arb: RTL

DRW_VRAMWR_ARB -- requirements
Module: drw_vramwr_arb

---
 rtl/drw_pkg.sv | 27 ++
 rtl/drw_vramwr_arb_if.sv | 38 +++
 rtl/drw_wrarb_sel.sv | 42 ++++
 rtl/drw_vramwr_arb.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/drw_pkg.sv
// Shared definitions for the VRAM write arbiter: FSM state encodings,
// AXI response codes and grant encodings.
package drw_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ADDR = 2'b01,
    S_DATA = 2'b10,
    S_RESP = 2'b11
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // GRANT is one-hot {S1,S0}
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_S0   = 2'b01;
  localparam logic [1:0] GNT_S1   = 2'b10;

  localparam int QUOTA_W = 4;

  function automatic logic [QUOTA_W-1:0] quota_next(input logic [QUOTA_W-1:0] cnt,
                                                    input logic [QUOTA_W-1:0] max);
    return (cnt >= max) ? max : cnt + 4'd1;
  endfunction

endpackage

// File: rtl/drw_vramwr_arb_if.sv
// AXI write-only channel bundle (AW/W/B) shared by both requesters and the VRAM master port.
interface drw_vramwr_arb_if;

  logic        AWVALID;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic        AWREADY;

  logic        WVALID;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WREADY;

  logic        BVALID;
  logic [1:0]  BRESP;
  logic        BREADY;

  modport master (
    output AWVALID, AWADDR, AWLEN, AWSIZE,
    input  AWREADY,
    output WVALID, WDATA, WSTRB, WLAST,
    input  WREADY,
    input  BVALID, BRESP,
    output BREADY
  );

  modport slave (
    input  AWVALID, AWADDR, AWLEN, AWSIZE,
    output AWREADY,
    input  WVALID, WDATA, WSTRB, WLAST,
    output WREADY,
    output BVALID, BRESP,
    input  BREADY
  );

endinterface

// File: rtl/drw_wrarb_sel.sv
// Grant selection for the VRAM write arbiter: S0 priority with a starvation
// quota that lets S1 through after BURST_QUOTA consecutive S0 bursts.
module drw_wrarb_sel
  import drw_pkg::*;
#(
  parameter int BURST_QUOTA = 4
) (
  input  logic ACLK,
  input  logic ARSTN,
  input  logic s0_req,
  input  logic s1_req,
  input  logic grant_en,
  output logic sel_s1
);

  localparam logic [QUOTA_W-1:0] QUOTA_MAX = QUOTA_W'(BURST_QUOTA);

  logic [QUOTA_W-1:0] quota_cnt_q;
  logic [QUOTA_W-1:0] quota_cnt_d;

  always_comb begin
    sel_s1      = s1_req && (!s0_req || (quota_cnt_q == QUOTA_MAX));
    quota_cnt_d = quota_cnt_q;
    // Count only S0 wins that actually made S1 wait; anything else restarts the window.
    if (grant_en) begin
      if (sel_s1 || !s1_req) begin
        quota_cnt_d = '0;
      end else begin
        quota_cnt_d = quota_next(quota_cnt_q, QUOTA_MAX);
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARSTN) begin
    if (!ARSTN) begin
      quota_cnt_q <= '0;
    end else begin
      quota_cnt_q <= quota_cnt_d;
    end
  end

endmodule

// File: rtl/drw_vramwr_arb.sv
// Two-port AXI write arbiter in front of VRAM: one burst outstanding at a time.
// Optional SLVERR/DECERR counter on ERR_CNT when DRW_WRARB_ERRCNT_EN is defined.
//
// state  | meaning
// S_IDLE | no owner; pick a requester and latch GRANT
// S_ADDR | forward owner's AW to VRAM until handshake
// S_DATA | pass owner's W beats through until WLAST handshake
// S_RESP | route VRAM B back to owner until handshake
module drw_vramwr_arb
  import drw_pkg::*;
#(
  parameter int BURST_QUOTA = 4
) (
  input  logic                    ACLK,
  input  logic                    ARSTN,
  drw_vramwr_arb_if.slave         S0,
  drw_vramwr_arb_if.slave         S1,
  drw_vramwr_arb_if.master        M,
  output logic [1:0]              GRANT,
  output logic                    BUSY
`ifdef DRW_WRARB_ERRCNT_EN
  ,
  output logic [15:0]             ERR_CNT
`endif
);

  state_t     state_q;
  state_t     state_d;
  logic [1:0] grant_q;
  logic [1:0] grant_d;

  logic sel_s1;
  logic grant_en;
  logic own_s1;
  logic aw_hs;
  logic w_last_hs;
  logic b_hs;

  assign grant_en = (state_q == S_IDLE) && (S0.AWVALID || S1.AWVALID);
  assign own_s1   = grant_q[1];

  drw_wrarb_sel #(
    .BURST_QUOTA (BURST_QUOTA)
  ) u_sel (
    .ACLK     (ACLK),
    .ARSTN    (ARSTN),
    .s0_req   (S0.AWVALID),
    .s1_req   (S1.AWVALID),
    .grant_en (grant_en),
    .sel_s1   (sel_s1)
  );

  // Channel routing: payload follows the owner, handshakes are gated by state.
  always_comb begin
    M.AWVALID  = 1'b0;
    M.AWADDR   = own_s1 ? S1.AWADDR : S0.AWADDR;
    M.AWLEN    = own_s1 ? S1.AWLEN  : S0.AWLEN;
    M.AWSIZE   = own_s1 ? S1.AWSIZE : S0.AWSIZE;
    M.WVALID   = 1'b0;
    M.WDATA    = own_s1 ? S1.WDATA  : S0.WDATA;
    M.WSTRB    = own_s1 ? S1.WSTRB  : S0.WSTRB;
    M.WLAST    = own_s1 ? S1.WLAST  : S0.WLAST;
    M.BREADY   = 1'b0;

    S0.AWREADY = 1'b0;
    S0.WREADY  = 1'b0;
    S0.BVALID  = 1'b0;
    S0.BRESP   = (grant_q == GNT_S0) ? M.BRESP : RESP_OKAY;
    S1.AWREADY = 1'b0;
    S1.WREADY  = 1'b0;
    S1.BVALID  = 1'b0;
    S1.BRESP   = (grant_q == GNT_S1) ? M.BRESP : RESP_OKAY;

    case (state_q)
      S_ADDR: begin
        M.AWVALID  = own_s1 ? S1.AWVALID : S0.AWVALID;
        S0.AWREADY = !own_s1 && M.AWREADY;
        S1.AWREADY =  own_s1 && M.AWREADY;
      end
      S_DATA: begin
        M.WVALID  = own_s1 ? S1.WVALID : S0.WVALID;
        S0.WREADY = !own_s1 && M.WREADY;
        S1.WREADY =  own_s1 && M.WREADY;
      end
      S_RESP: begin
        M.BREADY  = own_s1 ? S1.BREADY : S0.BREADY;
        S0.BVALID = !own_s1 && M.BVALID;
        S1.BVALID =  own_s1 && M.BVALID;
      end
      default: ;
    endcase

    aw_hs     = M.AWVALID && M.AWREADY;
    w_last_hs = M.WVALID && M.WREADY && M.WLAST;
    b_hs      = M.BVALID && M.BREADY;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      S_IDLE: begin
        if (grant_en) begin
          state_d = S_ADDR;
          grant_d = sel_s1 ? GNT_S1 : GNT_S0;
        end
      end
      S_ADDR: begin
        if (aw_hs) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (w_last_hs) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (b_hs) begin
          state_d = S_IDLE;
          grant_d = GNT_NONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = GNT_NONE;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARSTN) begin
    if (!ARSTN) begin
      state_q <= S_IDLE;
      grant_q <= GNT_NONE;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  assign GRANT = grant_q;
  assign BUSY  = (state_q != S_IDLE);

`ifdef DRW_WRARB_ERRCNT_EN
  logic [15:0] err_cnt_q;
  logic [15:0] err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (b_hs && (M.BRESP != RESP_OKAY) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge ACLK or negedge ARSTN) begin
    if (!ARSTN) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign ERR_CNT = err_cnt_q;
`endif

endmodule
